bb84_session_ctrl: RTL
======================

# bb84_session_ctrl

Session controller for the BB84 key-exchange datapath. Pulls random triples (Alice bit, Alice basis, Bob basis) from a handshaked source, drives one qubit slot at a time into the BB84 core, samples Bob's measured bit, and sifts matching-basis slots. Sifted bits are split into key bits and check bits; the check bits estimate the error rate. The block ends each session with either a full key or an abort.

## Interface
Parameters:
- KEY_LEN, 16: key bits to collect
- SLOT_MAX, 64: slot budget per session
- CHECK_EVERY, 4: every CHECK_EVERY-th sifted bit is sacrificed as a check bit (≥2)
- ERR_THRESH, 2: tolerated check mismatches (<255)
- DP_LAT, 1: datapath latency in cycles from dp_* driven to dp_a1 valid (≥1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin session (pulse)
- spy_req  in  1  enable eavesdropper for this session
- rng_valid  in  1  random triple available
- rng_data  in  3  {alice_bit, alice_basis, bob_basis}
- rng_ready  out  1  triple accepted when rng_valid & rng_ready
- dp_a  out  1  Alice bit to core (a)
- dp_b  out  1  Alice basis to core (b)
- dp_b1  out  1  Bob basis to core (b1)
- dp_spy  out  1  eavesdropper enable to core (spy)
- dp_a1  in  1  Bob measured bit from core (a1)
- key_out  out  KEY_LEN  collected key
- key_valid  out  1  key complete
- abort  out  1  session failed
- abort_cause  out  1  0 = error threshold, 1 = slot budget
- err_cnt  out  8  check mismatches, saturating at 255
- slot_cnt  out  $clog2(SLOT_MAX+1)  slots consumed
- busy  out  1  session in progress

## Operation
- States: IDLE, FETCH, DRIVE, SAMPLE, DONE, ABORT.
- IDLE:
  - On start, clear key_out, err_cnt, slot_cnt and the sift index.
  - Latch spy_req.
  - Go to FETCH.
- FETCH:
  - rng_ready=1.
  - On handshake, register rng_data into dp_a/dp_b/dp_b1, load the wait counter with DP_LAT, and go to DRIVE.
- DRIVE:
  - dp_* held.
  - Counter decrements; at 1, go to SAMPLE.
- SAMPLE:
  - slot_cnt += 1.
  - If dp_b != dp_b1, the slot is discarded.
  - Otherwise the slot is sifted, with sift index s:
    - If s mod CHECK_EVERY == CHECK_EVERY-1, it is a check bit: if dp_a1 != dp_a, err_cnt += 1.
    - Otherwise it is a key bit: key_out ← {key_out[KEY_LEN-2:0], dp_a}.
    - s += 1.
  - Next state, in priority order:
    - ABORT (cause 0) if err_cnt > ERR_THRESH.
    - Else DONE if the key holds KEY_LEN bits.
    - Else ABORT (cause 1) if slot_cnt == SLOT_MAX.
    - Else FETCH.
- DONE and ABORT:
  - key_valid and abort are level outputs, sticky until the next start.
  - start from DONE or ABORT restarts, identical to IDLE.
- start is ignored while busy (FETCH/DRIVE/SAMPLE).
- busy=1 in FETCH, DRIVE and SAMPLE.
- dp_* hold their last value outside DRIVE/SAMPLE.

## Timing
- Reset value of every output is 0, and the state is IDLE.
- Reset mid-session discards everything immediately.
- Handshake accepted at edge E0:
  - dp_* valid after E0.
  - dp_a1 sampled at edge E0+DP_LAT+1.
  - FETCH re-entered after that edge.
- Minimum slot period is DP_LAT+2 cycles; rng_valid low in FETCH stalls indefinitely.
- key_valid/abort rise on the edge that ends the deciding SAMPLE.
- key_out, err_cnt and slot_cnt are final at that same edge.
- First key bit ends up in key_out[KEY_LEN-1].

## Configuration
- BB84_SPY_EN defined:
  - spy_req is latched at start.
  - dp_spy drives the latched value for the whole session.
  - dp_spy clears to 0 in IDLE, DONE and ABORT.
- BB84_SPY_EN undefined:
  - spy_req is ignored.
  - dp_spy is constant 0.

## Test plan
All scenarios use default parameters and a zero-wait source unless noted.
- Bases always match, dp_a1 echoes dp_a: key_valid at slot 21 (5 check bits), key_out equals the 16 non-check Alice bits in order, err_cnt=0.
- Bases always differ: abort=1, abort_cause=1, slot_cnt=64, key_valid=0.
- Bases match, bench inverts dp_a1 on every check slot: abort at the 3rd mismatch (sifted index 11, slot 12), abort_cause=0, err_cnt=3.
- Source deasserts rng_valid for 10 cycles mid-session: rng_ready stays 1, dp_* and slot_cnt frozen, then session resumes and completes as in the first scenario.
- rst_n asserted during DRIVE: all outputs 0 immediately. start after reset: fresh session with slot_cnt counting from 0.
- With BB84_SPY_EN and spy_req=1 at start: dp_spy=1 through the session, 0 after done. Without the macro: dp_spy=0 throughout.

Source files
------------

// File: rtl/bb84_session_ctrl.sv
// bb84_session_ctrl: session controller for the BB84 key-exchange datapath.
// Each slot pulls one random triple {alice_bit, alice_basis, bob_basis},
// drives it into the core, samples Bob's bit and sifts matching-basis slots.
// Every CHECK_EVERY-th sifted bit is a check bit. Check mismatches are
// counted, and the session ends with a full key (DONE) or an abort.
// Optional feature: define BB84_SPY_EN to let spy_req, latched at start,
// enable the eavesdropper in the core for the whole session.
//
// Handshake: a triple transfers on a rising edge where rng_valid and
// rng_ready are both 1. rng_ready is 1 only in FETCH. The source may hold
// rng_valid low for any number of cycles.
module bb84_session_ctrl #(
    parameter int KEY_LEN     = 16,
    parameter int SLOT_MAX    = 64,
    parameter int CHECK_EVERY = 4,
    parameter int ERR_THRESH  = 2,
    parameter int DP_LAT      = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         spy_req,
    input  logic                         rng_valid,
    input  logic [2:0]                   rng_data,
    output logic                         rng_ready,
    output logic                         dp_a,
    output logic                         dp_b,
    output logic                         dp_b1,
    output logic                         dp_spy,
    input  logic                         dp_a1,
    output logic [KEY_LEN-1:0]           key_out,
    output logic                         key_valid,
    output logic                         abort,
    output logic                         abort_cause,
    output logic [7:0]                   err_cnt,
    output logic [$clog2(SLOT_MAX+1)-1:0] slot_cnt,
    output logic                         busy
);

    localparam int SW = $clog2(SLOT_MAX + 1);
    localparam int KW = $clog2(KEY_LEN + 1);
    localparam int CW = $clog2(CHECK_EVERY);
    localparam int WW = $clog2(DP_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DRIVE  = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4,
        S_ABORT  = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic                 dp_a_q, dp_a_d;
    logic                 dp_b_q, dp_b_d;
    logic                 dp_b1_q, dp_b1_d;
    logic [WW-1:0]        wait_q, wait_d;
    logic [KEY_LEN-1:0]   key_q, key_d;
    logic [KW-1:0]        key_cnt_q, key_cnt_d;
    logic [CW-1:0]        phase_q, phase_d;
    logic [7:0]           err_q, err_d;
    logic [SW-1:0]        slot_q, slot_d;
    logic                 cause_q, cause_d;

    logic start_ok;
    logic hs;
    logic sifted;
    logic is_check;
    logic err_over;
    logic key_full;
    logic slots_out;

    // Session-level control conditions
    assign start_ok  = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ABORT);
    assign hs        = (state_q == S_FETCH) && rng_valid;
    assign sifted    = (dp_b_q == dp_b1_q);
    assign is_check  = (phase_q == CW'(CHECK_EVERY - 1));
    assign err_over  = (err_d > 8'(ERR_THRESH));
    assign key_full  = (key_cnt_d == KW'(KEY_LEN));
    assign slots_out = (slot_d == SW'(SLOT_MAX));

    // Datapath next values: session clear, triple load, wait count, sifting
    always_comb begin
        dp_a_d    = dp_a_q;
        dp_b_d    = dp_b_q;
        dp_b1_d   = dp_b1_q;
        wait_d    = wait_q;
        key_d     = key_q;
        key_cnt_d = key_cnt_q;
        phase_d   = phase_q;
        err_d     = err_q;
        slot_d    = slot_q;
        cause_d   = cause_q;
        if (start_ok) begin
            key_d     = '0;
            key_cnt_d = '0;
            phase_d   = '0;
            err_d     = '0;
            slot_d    = '0;
            cause_d   = 1'b0;
        end
        if (hs) begin
            dp_a_d  = rng_data[2];
            dp_b_d  = rng_data[1];
            dp_b1_d = rng_data[0];
            wait_d  = WW'(DP_LAT);
        end
        if (state_q == S_DRIVE) begin
            wait_d = wait_q - WW'(1);
        end
        if (state_q == S_SAMPLE) begin
            slot_d = slot_q + SW'(1);
            if (sifted) begin
                if (is_check) begin
                    if (dp_a1 != dp_a_q && err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                    phase_d = '0;
                end else begin
                    key_d     = {key_q[KEY_LEN-2:0], dp_a_q};
                    key_cnt_d = key_cnt_q + KW'(1);
                    phase_d   = phase_q + CW'(1);
                end
            end
            // The error-threshold abort wins over everything, so the budget
            // cause is recorded only when neither earlier outcome applies.
            if (!err_over && !key_full && slots_out) begin
                cause_d = 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_a_q    <= 1'b0;
            dp_b_q    <= 1'b0;
            dp_b1_q   <= 1'b0;
            wait_q    <= '0;
            key_q     <= '0;
            key_cnt_q <= '0;
            phase_q   <= '0;
            err_q     <= '0;
            slot_q    <= '0;
            cause_q   <= 1'b0;
        end else begin
            dp_a_q    <= dp_a_d;
            dp_b_q    <= dp_b_d;
            dp_b1_q   <= dp_b1_d;
            wait_q    <= wait_d;
            key_q     <= key_d;
            key_cnt_q <= key_cnt_d;
            phase_q   <= phase_d;
            err_q     <= err_d;
            slot_q    <= slot_d;
            cause_q   <= cause_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; SAMPLE decides on the post-update counters
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ABORT: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (rng_valid) state_d = S_DRIVE;
            end
            S_DRIVE: begin
                if (wait_q == WW'(1)) state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (err_over)       state_d = S_ABORT;
                else if (key_full)  state_d = S_DONE;
                else if (slots_out) state_d = S_ABORT;
                else                state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef BB84_SPY_EN
    logic spy_q, spy_d;

    // Eavesdropper enable latched for the session at start
    always_comb begin
        spy_d = spy_q;
        if (start_ok) spy_d = spy_req;
    end

    // Latched eavesdropper enable register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) spy_q <= 1'b0;
        else        spy_q <= spy_d;
    end
`else
    logic unused_spy_req;
    assign unused_spy_req = spy_req;
`endif

    // FSM outputs decoded from the current state
    always_comb begin
        rng_ready = (state_q == S_FETCH);
        busy      = (state_q == S_FETCH) || (state_q == S_DRIVE) || (state_q == S_SAMPLE);
        key_valid = (state_q == S_DONE);
        abort     = (state_q == S_ABORT);
`ifdef BB84_SPY_EN
        dp_spy    = spy_q && busy;
`else
        dp_spy    = 1'b0;
`endif
    end

    assign dp_a        = dp_a_q;
    assign dp_b        = dp_b_q;
    assign dp_b1       = dp_b1_q;
    assign key_out     = key_q;
    assign abort_cause = cause_q;
    assign err_cnt     = err_q;
    assign slot_cnt    = slot_q;

endmodule
